uart_tx_controller: RTL and testbench

Transmit-side sequencer for the UART. It accepts a byte from the host on a load strobe and computes the two frame-tail bits, b9 and b10, from the word-format controls. It then serialises an 11-bit frame on `tx` at a programmable bit time and reports busy/ready and done to the host. It sits between the host register interface and the serial pin and owns the frame format, the bit timing and the load handshake.

---
 rtl/uart_tx_controller_if.sv | 26 ++
 rtl/uart_tx_controller.sv | 106 ++++++++++
 tb/tb_uart_tx_controller.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_controller_if.sv
// Host-side handshake bundle for uart_tx_controller: word-format controls,
// bit-time reload value, load strobe/data and the ready/done status.
interface uart_tx_controller_if #(
    parameter int unsigned BAUD_W = 19
);
    logic [BAUD_W-1:0] baud_k;
    logic              bit_8;
    logic              parity_en;
    logic              odd_n_even;
    logic              load;
    logic [7:0]        load_data;
    logic              tx_rdy;
    logic              tx_done;

    // Host drives the request side and observes the status.
    modport master (
        output baud_k, bit_8, parity_en, odd_n_even, load, load_data,
        input  tx_rdy, tx_done
    );

    // Controller receives the request side and reports status.
    modport slave (
        input  baud_k, bit_8, parity_en, odd_n_even, load, load_data,
        output tx_rdy, tx_done
    );
endinterface

// File: rtl/uart_tx_controller.sv
// UART transmit sequencer: latches a byte on load, builds an 11-bit frame
// (start, data[6:0], b9, b10, stop) and shifts it out LSB first on tx at
// baud_k+1 clocks per bit. Define UART_TX_PARITY_EN to build the parity
// generator; without it parity_en is treated as 0.
module uart_tx_controller #(
    parameter int unsigned BAUD_W = 19
) (
    input  logic                clk,
    input  logic                reset_n,
    uart_tx_controller_if.slave host,
    output logic                tx
);

    typedef enum logic {StIdle, StShift} state_e;

    state_e            state_q;
    logic [10:0]       shift_q;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_cnt_q;
    logic [3:0]        bit_cnt_q;
    logic              rdy_q;
    logic              done_q;
    logic              b9;
    logic              b10;

`ifdef UART_TX_PARITY_EN
    logic par7;
    logic par8;

    // Tail bits from the word-format controls, parity generator included.
    always_comb begin
        par7 = (^host.load_data[6:0]) ^ host.odd_n_even;
        par8 = (^host.load_data) ^ host.odd_n_even;
        b9   = 1'b1;
        b10  = 1'b1;
        unique case ({host.bit_8, host.parity_en})
            2'b01: b9 = par7;
            2'b10: b9 = host.load_data[7];
            2'b11: begin
                b9  = host.load_data[7];
                b10 = par8;
            end
            default: ;
        endcase
    end
`else
    logic unused_parity;
    assign unused_parity = host.parity_en ^ host.odd_n_even;

    // Tail bits with parity removed: b9 carries data[7] in 8-bit mode.
    always_comb begin
        b9  = host.bit_8 ? host.load_data[7] : 1'b1;
        b10 = 1'b1;
    end
`endif

    // Frame sequencer: accept a load in idle, then time and shift each bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            shift_q    <= '1;
            baud_q     <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            rdy_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (host.load) begin
                        shift_q    <= {1'b1, b10, b9, host.load_data[6:0], 1'b0};
                        baud_q     <= host.baud_k;
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        rdy_q      <= 1'b0;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    if (baud_cnt_q == baud_q) begin
                        baud_cnt_q <= '0;
                        // Shifting in ones leaves the line high after the stop bit.
                        shift_q    <= {1'b1, shift_q[10:1]};
                        if (bit_cnt_q == 4'd10) begin
                            bit_cnt_q <= '0;
                            done_q    <= 1'b1;
                            rdy_q     <= 1'b1;
                            state_q   <= StIdle;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx           = shift_q[0];
    assign host.tx_rdy  = rdy_q;
    assign host.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench for uart_tx_controller with a frame scoreboard.
module tb_uart_tx_controller;

    typedef struct {
        logic [10:0] bits;   // index 0 is the start bit
        int          k;
    } frame_t;

    logic   clk;
    logic   reset_n;
    logic   tx;
    int     n_tests;
    int     n_fail;
    frame_t sb[$];

    uart_tx_controller_if #(.BAUD_W(19)) bus ();

    uart_tx_controller #(.BAUD_W(19)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .host    (bus),
        .tx      (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] model_frame(input logic [7:0] d, input logic b8,
                                                input logic pe, input logic odd);
        logic p7, p8, t9, t10, pen;
        p7  = (^d[6:0]) ^ odd;
        p8  = (^d) ^ odd;
`ifdef UART_TX_PARITY_EN
        pen = pe;
`else
        pen = 1'b0;
`endif
        t9  = b8 ? d[7] : (pen ? p7 : 1'b1);
        t10 = (b8 && pen) ? p8 : 1'b1;
        return {1'b1, t10, t9, d[6:0], 1'b0};
    endfunction

    // Called at a negedge; the load is sampled at the following posedge.
    task automatic start_load(input logic [7:0] d, input logic b8, input logic pe,
                              input logic odd, input int k, input logic [10:0] exp);
        frame_t f;
        bus.load_data  = d;
        bus.bit_8      = b8;
        bus.parity_en  = pe;
        bus.odd_n_even = odd;
        bus.baud_k     = 19'(k);
        bus.load       = 1'b1;
        f.bits = exp;
        f.k    = k;
        sb.push_back(f);
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.load = 1'b0;
            chk("idle_tx", tx, 1'b1);
            chk("idle_rdy", bus.tx_rdy, 1'b1);
            chk("idle_done", bus.tx_done, 1'b0);
        end
    endtask

    // inj_kind 1: stray load of 0xAA; 2: change baud_k/controls/data mid-frame.
    task automatic check_frame(input int inj_cycle, input int inj_kind);
        frame_t e;
        int     len;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e   = sb.pop_front();
        len = 11 * (e.k + 1);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            bus.load = 1'b0;
            chk("tx_bit", tx, e.bits[c / (e.k + 1)]);
            chk("busy_rdy", bus.tx_rdy, 1'b0);
            chk("early_done", bus.tx_done, 1'b0);
            if (c == inj_cycle && inj_kind == 1) begin
                bus.load      = 1'b1;
                bus.load_data = 8'hAA;
            end else if (c == inj_cycle && inj_kind == 2) begin
                bus.baud_k     = 19'd7;
                bus.bit_8      = ~bus.bit_8;
                bus.parity_en  = ~bus.parity_en;
                bus.odd_n_even = ~bus.odd_n_even;
                bus.load_data  = ~bus.load_data;
            end
        end
        @(negedge clk);
        bus.load = 1'b0;
        chk("done_pulse", bus.tx_done, 1'b1);
        chk("done_rdy", bus.tx_rdy, 1'b1);
        chk("done_tx", tx, 1'b1);
    endtask

    initial begin
        logic [1:0] tail_tbl [8];
        logic [2:0] ctl;
        int         idx;
        frame_t     aborted;

        n_tests        = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        bus.load       = 1'b0;
        bus.load_data  = 8'h00;
        bus.bit_8      = 1'b0;
        bus.parity_en  = 1'b0;
        bus.odd_n_even = 1'b0;
        bus.baud_k     = 19'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_rdy", bus.tx_rdy, 1'b1);
        chk("rst_done", bus.tx_done, 1'b0);
        reset_n = 1'b1;
        idle_check(20);

        // 0x0F, 7 data bits, no parity, 4-clock bits
        start_load(8'h0F, 1'b0, 1'b0, 1'b0, 3, 11'b11100011110);
        check_frame(-1, 0);
        idle_check(3);

        // Tail bits for every control combination {bit_8, parity_en, odd_n_even}
        tail_tbl = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b00, 2'b01};
        for (int i = 0; i < 8; i++) begin
            ctl = 3'(i);
`ifdef UART_TX_PARITY_EN
            idx = i;
`else
            idx = i & 5;
`endif
            start_load(8'h0F, ctl[2], ctl[1], ctl[0], 0,
                       {1'b1, tail_tbl[idx][0], tail_tbl[idx][1], 7'h0F, 1'b0});
            check_frame(-1, 0);
            idle_check(2);
        end

        // Stray load mid-frame is ignored; load on the done cycle chains
        start_load(8'h55, 1'b1, 1'b0, 1'b0, 3, model_frame(8'h55, 1'b1, 1'b0, 1'b0));
        check_frame(5, 1);
        start_load(8'hAA, 1'b1, 1'b1, 1'b1, 3, model_frame(8'hAA, 1'b1, 1'b1, 1'b1));
        check_frame(-1, 0);
        idle_check(3);

        // Reset during bit 5 aborts the frame; reset beats a concurrent load
        start_load(8'h33, 1'b0, 1'b1, 1'b0, 3, model_frame(8'h33, 1'b0, 1'b1, 1'b0));
        aborted = sb.pop_front();
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            bus.load = 1'b0;
            chk("pre_abort_tx", tx, aborted.bits[c / 4]);
        end
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_tx", tx, 1'b1);
        chk("abort_rdy", bus.tx_rdy, 1'b1);
        chk("abort_done", bus.tx_done, 1'b0);
        bus.load      = 1'b1;
        bus.load_data = 8'h00;
        @(negedge clk);
        bus.load = 1'b0;
        chk("rst_load_tx", tx, 1'b1);
        chk("rst_load_rdy", bus.tx_rdy, 1'b1);
        reset_n = 1'b1;
        idle_check(12);

        // baud_k change mid-frame only affects the next frame
        start_load(8'h5A, 1'b1, 1'b1, 1'b0, 3, model_frame(8'h5A, 1'b1, 1'b1, 1'b0));
        check_frame(10, 2);
        idle_check(2);
        start_load(8'h5A, 1'b1, 1'b1, 1'b0, 7, model_frame(8'h5A, 1'b1, 1'b1, 1'b0));
        check_frame(-1, 0);
        idle_check(3);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
